// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler: wave codes, config field codes,
// FSM states and the amplitude/accumulator widths used by the scaling datapath.
`timescale 1ns/1ps
package voice_scheduler_pkg;

  typedef enum logic [2:0] {
    WAVE_SINE   = 3'd0,
    WAVE_SAW    = 3'd1,
    WAVE_SQUARE = 3'd2,
    WAVE_TRI    = 3'd3,
    WAVE_NOISE  = 3'd4
  } wave_e;

  typedef enum logic [1:0] {
    CFG_WAVE  = 2'd0,
    CFG_FCW   = 2'd1,
    CFG_AMP   = 2'd2,
    CFG_PHASE = 2'd3
  } cfg_field_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_PUBLISH
  } state_e;

  localparam int AMP_W     = 16;
  // Headroom bits above DATA_W so up to 8 full-scale terms cannot overflow the sum.
  localparam int ACC_GUARD = 4;

endpackage

// File: rtl/voice_scheduler_mac.sv
// Scales each captured sample by its unsigned amplitude, accumulates the frame
// and presents the saturated running sum (including this cycle's term).
`timescale 1ns/1ps
module voice_mac
  import voice_scheduler_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [AMP_W-1:0]  amp_i,
  output logic [DATA_W-1:0] mix_o
);

  localparam int SUM_W  = DATA_W + ACC_GUARD;
  localparam int PROD_W = DATA_W + AMP_W + 1;
  localparam logic signed [SUM_W-1:0] POS_LIM = SUM_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] NEG_LIM = SUM_W'(-(2 ** (DATA_W - 1)));

  logic signed [PROD_W-1:0] samp_x;
  logic signed [PROD_W-1:0] amp_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W:0]   term;
  logic signed [SUM_W-1:0]  acc_q;
  logic signed [SUM_W-1:0]  acc_d;

  always_comb begin
    samp_x = PROD_W'($signed(sample_i));
    amp_x  = PROD_W'({1'b0, amp_i});
    prod   = samp_x * amp_x;
    // Dropping the low AMP_W bits of a signed product is a floor divide by 2^16.
    term   = prod[PROD_W-1:AMP_W];
    acc_d  = acc_q + (cap_i ? SUM_W'(term) : '0);
    if (acc_d > POS_LIM) begin
      mix_o = POS_LIM[DATA_W-1:0];
    end else if (acc_d < NEG_LIM) begin
      mix_o = NEG_LIM[DATA_W-1:0];
    end else begin
      mix_o = acc_d[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Time-shares one wave-table lookup path among NUM_VOICES oscillators and mixes
// the amplitude-scaled samples into one saturated signed sample per frame.
`timescale 1ns/1ps
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 2,
  parameter int ACC_W      = 24,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LUT_LAT    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_cfg_we,
  input  logic [2:0]        i_cfg_voice,
  input  logic [1:0]        i_cfg_field,
  input  logic [ACC_W-1:0]  i_cfg_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic [2:0]        o_wave_sel,
  input  logic [DATA_W-1:0] i_wave_data,
  output logic [DATA_W-1:0] o_mix,
  output logic              o_mix_valid,
  output logic              o_busy
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  state_e              state_q;
  logic [2:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          wave_sel_q;
  logic [DATA_W-1:0]   mix_q;
  logic                mix_valid_q;
  logic                busy_q;

  logic [ACC_W-1:0]    phase_q    [NUM_VOICES];
  logic [ACC_W-1:0]    fcw_q      [NUM_VOICES];
  wave_e               wave_q     [NUM_VOICES];
  logic [AMP_W-1:0]    amp_q      [NUM_VOICES];
  logic [ACC_W-1:0]    sh_phase_q [NUM_VOICES];
  logic [ACC_W-1:0]    sh_fcw_q   [NUM_VOICES];
  wave_e               sh_wave_q  [NUM_VOICES];
  logic [AMP_W-1:0]    sh_amp_q   [NUM_VOICES];
  logic                ph_pend_q  [NUM_VOICES];

  // Stage 0 tracks the voice whose address is on o_addr; stage LUT_LAT is its data.
  logic                pv_q [LUT_LAT+1];
  logic [VW-1:0]       pi_q [LUT_LAT+1];

  logic                issue;
  logic                commit;
  logic                cfg_hit;
  logic [VW-1:0]       cfg_v;
  logic [VW-1:0]       vsel;
  logic                cap;
  logic [VW-1:0]       cap_idx;
  logic                mac_clr;
  logic [DATA_W-1:0]   mac_mix;

  assign issue   = (state_q == ST_ISSUE);
  assign commit  = (state_q == ST_IDLE) || (state_q == ST_PUBLISH);
  assign cfg_hit = i_cfg_we && ({29'd0, i_cfg_voice} < 32'(NUM_VOICES));
  assign cfg_v   = i_cfg_voice[VW-1:0];
  assign vsel    = cnt_q[VW-1:0];
  assign cap     = pv_q[LUT_LAT];
  assign cap_idx = pi_q[LUT_LAT];
  assign mac_clr = commit;

  // Live parameters only change at commit, so a frame always sees one consistent set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        phase_q[v]    <= '0;
        fcw_q[v]      <= '0;
        wave_q[v]     <= WAVE_SINE;
        amp_q[v]      <= '0;
        sh_phase_q[v] <= '0;
        sh_fcw_q[v]   <= '0;
        sh_wave_q[v]  <= WAVE_SINE;
        sh_amp_q[v]   <= '0;
        ph_pend_q[v]  <= 1'b0;
      end
    end else begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (commit) begin
          wave_q[v] <= sh_wave_q[v];
          fcw_q[v]  <= sh_fcw_q[v];
          amp_q[v]  <= sh_amp_q[v];
          if (ph_pend_q[v]) begin
            phase_q[v]   <= sh_phase_q[v];
            ph_pend_q[v] <= 1'b0;
          end
        end else if (issue && (vsel == VW'(v))) begin
          phase_q[v] <= phase_q[v] + fcw_q[v];
        end
        if (cfg_hit && (cfg_v == VW'(v))) begin
          case (cfg_field_e'(i_cfg_field))
            CFG_WAVE:  sh_wave_q[v] <= wave_e'(i_cfg_data[2:0]);
            CFG_FCW:   sh_fcw_q[v]  <= i_cfg_data;
            CFG_AMP:   sh_amp_q[v]  <= i_cfg_data[AMP_W-1:0];
            CFG_PHASE: begin
              sh_phase_q[v] <= i_cfg_data;
              ph_pend_q[v]  <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wave_sel_q  <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned k = 0; k <= LUT_LAT; k++) begin
        pv_q[k] <= 1'b0;
        pi_q[k] <= '0;
      end
    end else begin
      mix_valid_q <= 1'b0;
      pv_q[0]     <= issue;
      pi_q[0]     <= vsel;
      for (int unsigned k = 1; k <= LUT_LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
        pi_q[k] <= pi_q[k-1];
      end
      case (state_q)
        ST_IDLE: begin
          if (i_en) begin
            state_q <= ST_ISSUE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          addr_q     <= phase_q[vsel][ACC_W-1 -: ADDR_W];
          wave_sel_q <= wave_q[vsel];
          if (cnt_q == 3'(NUM_VOICES - 1)) begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == 3'(LUT_LAT - 1)) begin
            state_q <= ST_PUBLISH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_PUBLISH: begin
          // The last voice's sample lands this cycle; mac_mix already includes it.
          mix_q       <= mac_mix;
          mix_valid_q <= 1'b1;
          cnt_q       <= '0;
          if (i_en) begin
            state_q <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  voice_mac #(
    .DATA_W (DATA_W)
  ) u_mac (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .clr_i    (mac_clr),
    .cap_i    (cap),
    .sample_i (i_wave_data),
    .amp_i    (amp_q[cap_idx]),
    .mix_o    (mac_mix)
  );

  assign o_addr      = addr_q;
  assign o_wave_sel  = wave_sel_q;
  assign o_mix       = mix_q;
  assign o_mix_valid = mix_valid_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a one-cycle registered wave-table stub.
`timescale 1ns/1ps
module tb_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_voice = '0;
  logic [1:0]  cfg_field = '0;
  logic [23:0] cfg_data = '0;
  logic [15:0] addr;
  logic [2:0]  wsel;
  logic [15:0] wave_data = '0;
  logic [15:0] stub_val = '0;
  logic [15:0] mix;
  logic        mix_valid;
  logic        busy;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Table stub: LUT_LAT = 1 registered lookup returning a programmed sample.
  always @(posedge clk) wave_data <= stub_val;

  voice_scheduler #(
    .NUM_VOICES (2),
    .ACC_W      (24),
    .ADDR_W     (16),
    .DATA_W     (16),
    .LUT_LAT    (1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_cfg_we    (cfg_we),
    .i_cfg_voice (cfg_voice),
    .i_cfg_field (cfg_field),
    .i_cfg_data  (cfg_data),
    .o_addr      (addr),
    .o_wave_sel  (wsel),
    .i_wave_data (wave_data),
    .o_mix       (mix),
    .o_mix_valid (mix_valid),
    .o_busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cfg(input int v, input int f, input logic [23:0] d);
    cfg_we    = 1'b1;
    cfg_voice = 3'(v);
    cfg_field = 2'(f);
    cfg_data  = d;
    tick;
    cfg_we    = 1'b0;
  endtask

  task automatic reset_dut;
    en    = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Starts a frame from IDLE, drops i_en during ISSUE, expects exactly one pulse.
  task automatic one_frame(input string tag, input logic [15:0] exp);
    int pulses = 0;
    int at = 0;
    logic [15:0] got = '0;
    en = 1'b1;
    tick;
    en = 1'b0;
    for (int i = 2; i <= 12; i++) begin
      tick;
      if (mix_valid) begin
        pulses++;
        got = mix;
        at = i;
      end
    end
    check_eq({tag, "_mix"}, got, 32'(exp));
    check_eq({tag, "_pulses"}, pulses, 1);
    check_eq({tag, "_lat"}, at, 5);
    check_eq({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int first;
    int cnt;
    int last;

    // Reset with enable held high
    rst_n = 1'b0;
    en = 1'b1;
    repeat (5) tick;
    check_eq("rst_addr", 32'(addr), 0);
    check_eq("rst_wsel", 32'(wsel), 0);
    check_eq("rst_mix", 32'(mix), 0);
    check_eq("rst_valid", 32'(mix_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (i == 1) check_eq("run_busy", 32'(busy), 1);
      if (mix_valid && first == 0) first = i;
    end
    check_eq("first_valid", first, 5);
    check_eq("first_mix", 32'(mix), 0);

    // Phase stepping and wave select
    reset_dut;
    cfg(0, 1, 24'h010000);
    cfg(0, 0, 24'd3);
    tick;
    en = 1'b1;
    tick;
    tick;
    check_eq("ph_f0_addr", 32'(addr), 32'h0000);
    check_eq("ph_f0_wsel", 32'(wsel), 3);
    tick;
    check_eq("ph_v1_addr", 32'(addr), 32'h0000);
    check_eq("ph_v1_wsel", 32'(wsel), 0);
    repeat (3) tick;
    check_eq("ph_f1_addr", 32'(addr), 32'h0100);
    repeat (4) tick;
    check_eq("ph_f2_addr", 32'(addr), 32'h0200);
    en = 1'b0;
    repeat (8) tick;

    // Phase preset and accumulator wrap
    reset_dut;
    cfg(0, 3, 24'hFFFF00);
    cfg(0, 1, 24'h000200);
    tick;
    en = 1'b1;
    tick;
    tick;
    check_eq("wrap_pre", 32'(addr), 32'hFFFF);
    repeat (4) tick;
    check_eq("wrap_post", 32'(addr), 32'h0001);
    en = 1'b0;
    repeat (8) tick;

    // Steady mixing cadence
    reset_dut;
    stub_val = 16'h4000;
    cfg(0, 2, 24'h008000);
    cfg(1, 2, 24'h008000);
    tick;
    en = 1'b1;
    first = 0;
    cnt = 0;
    last = 0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (mix_valid) begin
        if (first == 0) first = i;
        cnt++;
        last = i;
      end
    end
    check_eq("mix_first", first, 5);
    check_eq("mix_count", cnt, 4);
    check_eq("mix_last", last, 17);
    check_eq("mix_val", 32'(mix), 32'h4000);
    en = 1'b0;
    repeat (8) tick;

    // Scaling, floor and saturation
    stub_val = 16'h7FFF;
    cfg(0, 2, 24'h00FFFF);
    cfg(1, 2, 24'h00FFFF);
    one_frame("sat_pos", 16'h7FFF);
    stub_val = 16'h8000;
    tick;
    one_frame("sat_neg", 16'h8000);
    stub_val = 16'hC000;
    cfg(0, 2, 24'h008000);
    cfg(1, 2, 24'h008000);
    one_frame("neg_half", 16'hC000);
    stub_val = 16'hFFFF;
    cfg(0, 2, 24'h000001);
    cfg(1, 2, 24'h000000);
    one_frame("floor", 16'hFFFF);

    // FCW written mid-ISSUE applies from the next frame
    reset_dut;
    cfg(1, 1, 24'h010000);
    tick;
    en = 1'b1;
    tick;
    cfg(1, 1, 24'h020000);
    tick;
    check_eq("fcw_f0", 32'(addr), 32'h0000);
    repeat (4) tick;
    check_eq("fcw_f1", 32'(addr), 32'h0100);
    repeat (4) tick;
    check_eq("fcw_f2", 32'(addr), 32'h0300);
    en = 1'b0;
    repeat (8) tick;

    // Writes to a voice index beyond NUM_VOICES are ignored
    reset_dut;
    cfg(1, 1, 24'h010000);
    cfg(5, 1, 24'h400000);
    cfg(5, 0, 24'd4);
    tick;
    en = 1'b1;
    repeat (3) tick;
    check_eq("v5_f0_addr", 32'(addr), 32'h0000);
    check_eq("v5_f0_wsel", 32'(wsel), 0);
    repeat (4) tick;
    check_eq("v5_f1_addr", 32'(addr), 32'h0100);
    en = 1'b0;
    repeat (8) tick;

    // Two amp writes in one frame: last wins, applied next frame
    reset_dut;
    stub_val = 16'h4000;
    cfg(0, 2, 24'h008000);
    tick;
    en = 1'b1;
    tick;
    cfg(0, 2, 24'h00FFFF);
    cfg(0, 2, 24'h004000);
    tick;
    tick;
    check_eq("amp_f0_valid", 32'(mix_valid), 1);
    check_eq("amp_f0_mix", 32'(mix), 32'h2000);
    repeat (4) tick;
    check_eq("amp_f1_valid", 32'(mix_valid), 1);
    check_eq("amp_f1_mix", 32'(mix), 32'h1000);
    en = 1'b0;
    repeat (8) tick;

    // Reset during DRAIN aborts the frame
    reset_dut;
    stub_val = 16'h4000;
    cfg(0, 2, 24'h008000);
    tick;
    en = 1'b1;
    repeat (3) tick;
    rst_n = 1'b0;
    tick;
    check_eq("abort_busy", 32'(busy), 0);
    rst_n = 1'b1;
    en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (mix_valid) cnt++;
    end
    check_eq("abort_pulses", cnt, 0);
    check_eq("abort_mix", 32'(mix), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
